mac_result_drain: RTL
=====================

Name: mac_result_drain

Overview:
- Read side of the MAC accumulator block's four result lanes.
- On a snapshot request, captures the four lane outputs and the active width mode into shadow registers.
- Emits the captured results as a stream of MAC_ACC_WIDTH-bit words over a valid/ready handshake, with per-result framing.
- Sits between the MAC array and the result bus, so the accumulators can keep running while results drain.

Parameters:
- MAC_CONF_WIDTH, 3, config field width; mode is the low MAC_CONF_WIDTH-1 bits.
- MAC_MIN_WIDTH, 8, base lane granularity; informational, not used in datapath.
- MAC_ACC_WIDTH, 4*MAC_MIN_WIDTH, width of each lane and of each output word.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  MAC_CONF_WIDTH-1  `MAC_DUAL / `MAC_QUAD from mac_const.vh; any other code is single.
- lane_mask  input  4  result enable; single: bit i = lane i; dual: bit0 = pair{1,0}, bit2 = pair{3,2}; quad: bit0 only; other bits ignored.
- in0, in1, in2, in3  input  MAC_ACC_WIDTH each  lane results from the accumulator block.
- snap  input  1  capture request; accepted when snap && snap_ready.
- snap_ready  output  1  high only in IDLE.
- out_data  output  MAC_ACC_WIDTH  current word.
- out_idx  output  2  lane index of current word.
- out_last  output  1  high on the final (most significant) word of a result.
- out_valid  output  1  word valid.
- out_ready  input  1  consumer accepts word.
- done  output  1  one-cycle pulse after the last word of a snapshot is accepted.

Behaviour:
- Reset (async, any state) values:
  - State IDLE; snap_ready=1; out_valid=0; out_last=0; done=0.
  - out_data=0; out_idx=0; shadow registers and captured mode/mask = 0.
- Lane emit set E, derived from the captured mode/mask:
  - single: E = {i : mask[i]}.
  - dual: lanes 0,1 if mask[0]; lanes 2,3 if mask[2].
  - quad: lanes 0..3 if mask[0].
  - Words are emitted in ascending lane order; lanes outside E are skipped with no bubble cycles.
- out_last:
  - single: every word.
  - dual: idx 1 and 3.
  - quad: idx 3.
- States: IDLE, SEND, FLUSH.
- IDLE:
  - On snap: latch in0..in3, mode, lane_mask into shadow registers.
  - If E is non-empty, go to SEND with idx = lowest lane in E.
  - If E is empty, go to FLUSH.
- SEND:
  - out_valid=1; out_data=shadow[idx]; out_idx=idx; out_last per rule above.
  - Outputs hold stable while out_valid && !out_ready.
  - On handshake with a higher lane remaining in E: idx advances to the next lane in E in the following cycle, out_valid stays high.
  - On handshake of the highest lane in E: go to IDLE; out_valid=0 next cycle; done=1 for that one cycle.
- FLUSH: one cycle; returns to IDLE with done=1 in that cycle; no words emitted.
- Latency:
  - snap accepted at edge N → first word valid in cycle N+1.
  - Final handshake at edge M → snap_ready=1 and done=1 in cycle M+1.
  - The earliest next snap is accepted at edge M+1, so there is one IDLE bubble between snapshots.
  - Sustained throughput is one word per cycle while out_ready=1.
- snap while not IDLE: ignored; shadow registers are not updated; no queueing.
- Inputs in0..in3, mode and lane_mask may change freely after capture; the stream uses only shadowed values.
- No arithmetic or sign handling; words are bit-exact copies of the lanes.
  - A dual result is {in1,in0} or {in3,in2}, low word first.
  - A quad result is {in3,in2,in1,in0}, low word first.
- Reset asserted mid-stream: immediate abort; all outputs drop to reset values asynchronously; no done pulse.

Test Plan:
- Single, mask=4'b1111, in0..3 = 32'h11,22,33,44, out_ready=1 → four words 11,22,33,44, idx 0..3, out_last=1 on each, valid cycles N+1..N+4, done at N+5.
- Dual, mask=4'b0101, in = 32'hA0,A1,B0,B1, out_ready toggling 1,0,1,0… → words A0,A1,B0,B1, each held stable across stall cycles, out_last on A1 and B1 only.
- Quad, mask=4'b0001, in = 32'hDEAD0000,1,2,3; in0..3 changed to 0 the cycle after snap → words DEAD0000,1,2,3 from shadow, out_last only on idx 3.
- Single, mask=4'b1010 → two words, idx 1 then 3, no bubble between; mask=4'b0000 → no out_valid, done pulse exactly one cycle after snap.
- snap held high throughout a quad drain with out_ready=0 for 3 cycles → only the first snap is captured; next capture occurs the cycle snap_ready returns.
- rst pulsed while out_valid=1 mid-stall → out_valid, out_data, done go to 0 immediately; snap_ready=1 after release; no done pulse.

Source files
------------

// File: rtl/mac_result_drain.sv
// mac_result_drain
//
// Read side of the MAC accumulator's four result lanes. A snapshot request
// copies the four lane values plus the active mode and lane mask into shadow
// registers, then streams the enabled lanes out one word per handshake so the
// accumulators are free to keep running while the results drain.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   mode        width mode (dual / quad, anything else is single)
//   lane_mask   result enable bits, interpreted per mode
//   in0..in3    lane results from the accumulator block
//   snap        capture request, taken when snap && snap_ready
//   snap_ready  high while idle
//   out_data    current word
//   out_idx     lane index of the current word
//   out_last    marks the most significant word of a result
//   out_valid   word valid
//   out_ready   consumer accepts the word
//   done        one-cycle pulse once a snapshot has fully drained
module mac_result_drain #(
    parameter int MAC_CONF_WIDTH = 3,
    parameter int MAC_MIN_WIDTH  = 8,
    parameter int MAC_ACC_WIDTH  = 4 * MAC_MIN_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [MAC_CONF_WIDTH-2:0]   mode,
    input  logic [3:0]                  lane_mask,
    input  logic [MAC_ACC_WIDTH-1:0]    in0,
    input  logic [MAC_ACC_WIDTH-1:0]    in1,
    input  logic [MAC_ACC_WIDTH-1:0]    in2,
    input  logic [MAC_ACC_WIDTH-1:0]    in3,
    input  logic                        snap,
    output logic                        snap_ready,
    output logic [MAC_ACC_WIDTH-1:0]    out_data,
    output logic [1:0]                  out_idx,
    output logic                        out_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        done
);

    localparam int MW = MAC_CONF_WIDTH - 1;

    // Mode encodings shared with the accumulator block's constant header.
    localparam logic [MW-1:0] MODE_DUAL = MW'(1);
    localparam logic [MW-1:0] MODE_QUAD = MW'(2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                     state;
    logic [MAC_ACC_WIDTH-1:0]   shadow [4];
    logic [MW-1:0]              cap_mode;
    logic [3:0]                 cap_mask;

    logic [MAC_ACC_WIDTH-1:0]   in_arr [4];
    logic [3:0]                 snap_emit;
    logic [3:0]                 snap_last;
    logic [2:0]                 snap_first;
    logic [3:0]                 cap_emit;
    logic [3:0]                 cap_last;
    logic [2:0]                 send_next;

    // Expands the mask into the set of lanes that produce words. Pair and
    // quad results are enabled by their lowest mask bit only.
    function automatic logic [3:0] emit_set(input logic [MW-1:0] m, input logic [3:0] k);
        logic [3:0] e;
        case (m)
            MODE_DUAL: e = {k[2], k[2], k[0], k[0]};
            MODE_QUAD: e = {4{k[0]}};
            default:   e = k;
        endcase
        return e;
    endfunction

    // Lanes that carry the most significant word of a result.
    function automatic logic [3:0] last_set(input logic [MW-1:0] m);
        logic [3:0] l;
        case (m)
            MODE_DUAL: l = 4'b1010;
            MODE_QUAD: l = 4'b1000;
            default:   l = 4'b1111;
        endcase
        return l;
    endfunction

    // Lowest enabled lane at or above start; bit 2 of the result flags a hit.
    // start may be 4, meaning no lane can qualify.
    function automatic logic [2:0] find_from(input logic [3:0] set, input logic [2:0] start);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (set[i] && (i >= int'(start))) begin
                r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

    assign in_arr[0] = in0;
    assign in_arr[1] = in1;
    assign in_arr[2] = in2;
    assign in_arr[3] = in3;

    // The first word is loaded straight from the live inputs at capture time,
    // since the shadow copy only becomes visible a cycle later. Afterwards the
    // stream walks the captured emit set using the shadow copy only.
    assign snap_emit  = emit_set(mode, lane_mask);
    assign snap_last  = last_set(mode);
    assign snap_first = find_from(snap_emit, 3'd0);
    assign cap_emit   = emit_set(cap_mode, cap_mask);
    assign cap_last   = last_set(cap_mode);
    assign send_next  = find_from(cap_emit, {1'b0, out_idx} + 3'd1);

    assign snap_ready = (state == IDLE);

    // Capture, stream and completion control. All stream outputs are
    // registered; the next word is prepared on the handshake edge so a
    // consumer with out_ready held high sees one word every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= '0;
            end
            cap_mode  <= '0;
            cap_mask  <= '0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (snap) begin
                        shadow[0] <= in0;
                        shadow[1] <= in1;
                        shadow[2] <= in2;
                        shadow[3] <= in3;
                        cap_mode  <= mode;
                        cap_mask  <= lane_mask;
                        if (snap_first[2]) begin
                            state     <= SEND;
                            out_valid <= 1'b1;
                            out_idx   <= snap_first[1:0];
                            out_data  <= in_arr[snap_first[1:0]];
                            out_last  <= snap_last[snap_first[1:0]];
                        end else begin
                            // Nothing to emit: the done pulse coincides with
                            // the single flush cycle.
                            state <= FLUSH;
                            done  <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (send_next[2]) begin
                            out_idx  <= send_next[1:0];
                            out_data <= shadow[send_next[1:0]];
                            out_last <= cap_last[send_next[1:0]];
                        end else begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
